// File: rtl/dmem_pkg.sv
// Shared definitions for the pipelined data memory.
//   dmem_state_e : access sequencer states
//   LS_*         : encodings of the load_store_type field
//   ls_bytes()   : number of bytes touched by a given access type
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2,
    RESP   = 2'd3
  } dmem_state_e;

  localparam logic [1:0] LS_BYTE   = 2'd0;
  localparam logic [1:0] LS_HALF   = 2'd1;
  localparam logic [1:0] LS_WORD   = 2'd2;
  localparam logic [1:0] LS_DOUBLE = 2'd3;

  function automatic int ls_bytes(input logic [1:0] ls_type);
    return 1 << ls_type;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data memory.
//   offset      : byte offset of the access inside its first word
//   ls_type     : access size code (byte/half/word/double)
//   wdata       : LSB-aligned store data
//   ld_buf      : two-word load buffer, first word in the low half
//   load_unsigned : zero-extend (1) or sign-extend (0) load results
//   byte_en     : lanes touched, low BPW bits = first word, high = next word
//   wdata_shift : store data moved onto its lanes across the two words
//   load_data   : assembled little-endian load result, extended
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [$clog2(DATA_WIDTH/8)-1:0] offset,
  input  logic [1:0]                      ls_type,
  input  logic [DATA_WIDTH-1:0]           wdata,
  input  logic [2*DATA_WIDTH-1:0]         ld_buf,
  input  logic                            load_unsigned,
  output logic [2*(DATA_WIDTH/8)-1:0]     byte_en,
  output logic [2*DATA_WIDTH-1:0]         wdata_shift,
  output logic [DATA_WIDTH-1:0]           load_data
);

  localparam int BPW = DATA_WIDTH / 8;

  logic [2*BPW-1:0]        size_mask;
  logic [2*DATA_WIDTH-1:0] raw_wide;
  logic [DATA_WIDTH-1:0]   raw;
  logic                    fill;
  int                      nbytes;
  int                      nbits;

  always_comb begin
    nbytes = ls_bytes(ls_type);
    // A double on a 32-bit memory is rejected upstream; clamp so the
    // extension logic never looks past the word.
    nbits = (nbytes * 8 > DATA_WIDTH) ? DATA_WIDTH : nbytes * 8;

    for (int i = 0; i < 2 * BPW; i++) begin
      size_mask[i] = (i < nbytes);
    end
    byte_en     = size_mask << offset;
    wdata_shift = {{DATA_WIDTH{1'b0}}, wdata} << {offset, 3'b000};

    // Shift the buffered lanes back down so the access starts at bit 0.
    raw_wide = ld_buf >> {offset, 3'b000};
    raw      = raw_wide[DATA_WIDTH-1:0];

    fill = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i == nbits - 1) begin
        fill = raw[i] & ~load_unsigned;
      end
    end
    for (int i = 0; i < DATA_WIDTH; i++) begin
      load_data[i] = (i < nbits) ? raw[i] : fill;
    end
  end

endmodule

// File: rtl/pipelined_data_memory.sv
// Byte-addressable data memory with a valid/ready request and response
// handshake. Each request is sequenced through FIRST (first word) and,
// when it straddles a word boundary, SECOND (next word) before the
// response is presented in RESP.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : request handshake; ready only while idle
//   req_write, req_addr, req_wdata, load_store_type, load_unsigned : request
//   resp_valid/resp_ready : response handshake
//   resp_rdata, resp_err  : extended load data (0 for stores/errors), error
module pipelined_data_memory
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int NUM_LOCS         = 64,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            load_store_type,
  input  logic                  load_unsigned,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BPW);
  localparam int IDX_W = (NUM_LOCS > 1) ? $clog2(NUM_LOCS) : 1;
  localparam int WI_W  = ADDR_WIDTH - OFF_W + 1;
  localparam logic [WI_W-1:0] LOCS_W = WI_W'(NUM_LOCS);
  localparam logic [WI_W-1:0] ONE_W  = WI_W'(1);

  dmem_state_e state_q, state_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [1:0]              lst_q, lst_d;
  logic                    uns_q, uns_d;
  logic [2*DATA_WIDTH-1:0] ld_buf_q, ld_buf_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   mem_q [NUM_LOCS];
  logic [DATA_WIDTH-1:0]   mem_d [NUM_LOCS];

  logic [OFF_W-1:0]        offset;
  logic [WI_W-1:0]         widx;
  logic [WI_W-1:0]         widx_next;
  logic [IDX_W-1:0]        idx1;
  logic [IDX_W-1:0]        idx2;
  logic [2*BPW-1:0]        byte_en;
  logic [2*DATA_WIDTH-1:0] wdata_shift;
  logic [DATA_WIDTH-1:0]   load_data;
  logic                    crosses;
  logic                    acc_err;

  // Address decode of the captured request. The word index is kept one
  // bit wider than the address so index+1 never wraps back to word 0.
  assign offset    = addr_q[OFF_W-1:0];
  assign widx      = {1'b0, addr_q[ADDR_WIDTH-1:OFF_W]};
  assign widx_next = widx + ONE_W;
  assign idx1      = widx[IDX_W-1:0];
  assign idx2      = widx_next[IDX_W-1:0];
  assign crosses   = |byte_en[2*BPW-1:BPW];
  assign acc_err   = ((lst_q == LS_DOUBLE) && (DATA_WIDTH == 32))
                   || (widx >= LOCS_W)
                   || (crosses && ((ALLOW_MISALIGNED == 0) || (widx_next >= LOCS_W)));

  dmem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .offset        (offset),
    .ls_type       (lst_q),
    .wdata         (wdata_q),
    .ld_buf        (ld_buf_d),
    .load_unsigned (uns_q),
    .byte_en       (byte_en),
    .wdata_shift   (wdata_shift),
    .load_data     (load_data)
  );

  // Memory lanes and load buffer: first word in FIRST, next word in SECOND.
  always_comb begin
    mem_d    = mem_q;
    ld_buf_d = ld_buf_q;
    case (state_q)
      IDLE: begin
        if (req_valid) ld_buf_d = '0;
      end
      FIRST: begin
        if (!acc_err) begin
          for (int b = 0; b < BPW; b++) begin
            if (byte_en[b]) begin
              if (write_q) mem_d[idx1][b*8 +: 8] = wdata_shift[b*8 +: 8];
              else         ld_buf_d[b*8 +: 8]   = mem_q[idx1][b*8 +: 8];
            end
          end
        end
      end
      SECOND: begin
        for (int b = 0; b < BPW; b++) begin
          if (byte_en[BPW+b]) begin
            if (write_q) mem_d[idx2][b*8 +: 8] = wdata_shift[DATA_WIDTH+b*8 +: 8];
            else         ld_buf_d[DATA_WIDTH+b*8 +: 8] = mem_q[idx2][b*8 +: 8];
          end
        end
      end
      default: ;
    endcase
  end

  // Sequencer, request capture and response registers.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lst_d   = lst_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          lst_d   = load_store_type;
          uns_d   = load_unsigned;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = FIRST;
        end
      end
      FIRST: begin
        if (acc_err) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (crosses) begin
          state_d = SECOND;
        end else begin
          rdata_d = write_q ? '0 : load_data;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      SECOND: begin
        rdata_d = write_q ? '0 : load_data;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      lst_q    <= '0;
      uns_q    <= 1'b0;
      ld_buf_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < NUM_LOCS; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      lst_q    <= lst_d;
      uns_q    <= uns_d;
      ld_buf_q <= ld_buf_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      for (int i = 0; i < NUM_LOCS; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: doc/pipelined_data_memory.md
PIPELINED_DATA_MEMORY -- requirements
Module: pipelined_data_memory

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter ADDR_WIDTH, default 32: byte-address width.
REQ-003 Parameter DATA_WIDTH, default 32, legal 32 or 64: word width; BPW = DATA_WIDTH/8 bytes per word.
REQ-004 Parameter NUM_LOCS, default 64: number of words.
REQ-005 Parameter ALLOW_MISALIGNED, default 1: 1 splits word-crossing accesses; 0 flags them as errors.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 req_valid  in  1  request present.
REQ-009 req_ready  out  1  block can accept a request.
REQ-010 req_write  in  1  1 = store, 0 = load.
REQ-011 req_addr  in  ADDR_WIDTH  byte address.
REQ-012 req_wdata  in  DATA_WIDTH  store data, LSB-aligned.
REQ-013 load_store_type  in  2  0 byte, 1 half, 2 word, 3 double (legal only when DATA_WIDTH=64).
REQ-014 load_unsigned  in  1  zero-extend (1) or sign-extend (0) loads.
REQ-015 resp_valid  out  1  response present.
REQ-016 resp_ready  in  1  consumer accepts the response.
REQ-017 resp_rdata  out  DATA_WIDTH  load result, extended; 0 for stores and errors.
REQ-018 resp_err  out  1  access rejected.

Function
REQ-019 FSM states SHALL be IDLE, FIRST, SECOND, RESP; req_ready = (state==IDLE).
REQ-020 On req_valid&&req_ready, all request fields SHALL be captured into registers and the FSM SHALL move to FIRST.
REQ-021 Access size SHALL be 2^load_store_type bytes, starting at byte (req_addr mod BPW) of word (req_addr / BPW).
REQ-022 An access is an error if: type 3 with DATA_WIDTH=32; any touched word index is >= NUM_LOCS; or it crosses a word boundary with ALLOW_MISALIGNED=0.
REQ-023 On an error, FIRST SHALL go directly to RESP with resp_err=1, resp_rdata=0, and memory unchanged.
REQ-024 In FIRST, only the byte lanes of the first word touched by the access SHALL be written (store) or latched (load).
REQ-025 From FIRST, an access that crosses into the next word SHALL go to SECOND; otherwise it SHALL go to RESP.
REQ-026 In SECOND, the remaining bytes SHALL be accessed in word index+1, then the FSM SHALL go to RESP.
REQ-027 Load data SHALL be assembled little-endian, then zero- or sign-extended to DATA_WIDTH according to load_unsigned.
REQ-028 resp_valid SHALL be high only in RESP, and resp_rdata/resp_err SHALL be held stable until resp_ready.
REQ-029 RESP->IDLE SHALL occur on resp_ready.
REQ-030 Latency from accept to resp_valid SHALL be 2 cycles for single-word accesses and 3 cycles for split accesses.
REQ-031 Requests SHALL NOT overlap: one request is outstanding at most, and a new accept is possible in the cycle after the RESP handshake.
REQ-032 Byte-address wrap-around SHALL NOT occur; an access beyond the last word SHALL be flagged by REQ-022.

Reset
REQ-033 rst SHALL immediately force state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-034 rst SHALL clear all memory words to 0 and all capture registers to 0.
REQ-035 rst asserted mid-access SHALL abort the access, with no partial write surviving; a store split across two words SHALL leave both words zero.

Structure
REQ-036 Package dmem_pkg SHALL hold the FSM state enum and the constants LS_BYTE=0, LS_HALF=1, LS_WORD=2, LS_DOUBLE=3.
REQ-037 Combinational sub-module dmem_lane_align SHALL perform byte-lane shift, byte-enable generation and load extension.

Verification
REQ-038 Store word 0xDEADBEEF @0x08, then load word @0x08 -> resp_rdata=0xDEADBEEF, err=0, resp_valid 2 cycles after accept.
REQ-039 Load byte @0x0B signed -> 0xFFFFFFDE; load byte @0x0B unsigned -> 0x000000DE; load half @0x0A unsigned -> 0x0000DEAD.
REQ-040 ALLOW_MISALIGNED=1: store word 0x11223344 @0x0E, then load word @0x0E -> 0x11223344, 3-cycle latency; word 3 bytes 2-3 and word 4 bytes 0-1 are updated.
REQ-041 Load @NUM_LOCS*4 -> err=1, rdata=0; ALLOW_MISALIGNED=0 with store half @0x03 -> err=1 and memory unchanged; type 3 with DATA_WIDTH=32 -> err=1.
REQ-042 resp_ready held low 5 cycles -> resp_valid/rdata stable, req_ready=0; rst pulsed during SECOND of a split store -> IDLE, outputs 0, both words read back 0.
